// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - shared types and widths for the inter-stage pipeline registers
package pipe_pkg;

   localparam int CTRL_W = 7;

   typedef struct packed {
      logic branch;
      logic mem_read;
      logic mem_to_reg;
      logic mem_write;
      logic reg_write;
      logic jal;
      logic jalr;
   } ctrl_t;

   // Payload widths per stage boundary.
   localparam int IF_ID_DATA_W  = 64;   // pc, instruction
   localparam int ID_EX_DATA_W  = 133;  // pc, rs1, rs2, imm, rd
   localparam int EX_MEM_DATA_W = 97;   // alu_result, store data, pc+4, zero
   localparam int MEM_WB_DATA_W = 101;  // read data, alu_result, pc+4, rd

   // Encoding equals the number of held entries.
   typedef enum logic [1:0] {
      OCC_EMPTY = 2'd0,
      OCC_ONE   = 2'd1,
      OCC_TWO   = 2'd2
   } occ_state_e;

   function automatic logic [1:0] occ_count(input occ_state_e s);
      return logic'(s == OCC_TWO) ? 2'd2 : ((s == OCC_ONE) ? 2'd1 : 2'd0);
   endfunction

endpackage

// File: rtl/pipe_stage_reg_if.sv
// rtl/pipe_stage_reg_if.sv - handshake bundle between two pipeline stages
interface pipe_stage_reg_if #(
   parameter int CTRL_W = pipe_pkg::CTRL_W,
   parameter int DATA_W = pipe_pkg::EX_MEM_DATA_W
);
   logic              flush;
   logic              in_valid;
   logic              in_ready;
   logic [CTRL_W-1:0] in_ctrl;
   logic [DATA_W-1:0] in_data;
   logic              out_valid;
   logic              out_ready;
   logic [CTRL_W-1:0] out_ctrl;
   logic [DATA_W-1:0] out_data;
   logic [1:0]        occ;

   modport master (
      output flush, in_valid, in_ctrl, in_data, out_ready,
      input  in_ready, out_valid, out_ctrl, out_data, occ
   );

   modport slave (
      input  flush, in_valid, in_ctrl, in_data, out_ready,
      output in_ready, out_valid, out_ctrl, out_data, occ
   );
endinterface

// File: rtl/pipe_stage_reg.sv
// rtl/pipe_stage_reg.sv - valid/ready pipeline register with flush and optional skid entry
module pipe_stage_reg #(
   parameter int CTRL_W = pipe_pkg::CTRL_W,
   parameter int DATA_W = pipe_pkg::EX_MEM_DATA_W,
   parameter bit SKID   = 1'b1
) (
   input  logic            clk,
   input  logic            rst,
   pipe_stage_reg_if.slave bus
);
   import pipe_pkg::*;

   logic in_fire;
   logic out_fire;

   assign in_fire  = bus.in_valid & bus.in_ready;
   assign out_fire = bus.out_valid & bus.out_ready;

   if (SKID) begin : g_skid
      occ_state_e        state_q,    state_d;
      logic              in_ready_q, in_ready_d;
      logic [CTRL_W-1:0] m_ctrl_q,   m_ctrl_d;
      logic [DATA_W-1:0] m_data_q,   m_data_d;
      logic [CTRL_W-1:0] s_ctrl_q,   s_ctrl_d;
      logic [DATA_W-1:0] s_data_q,   s_data_d;

      always_comb begin
         state_d  = state_q;
         m_ctrl_d = m_ctrl_q;
         m_data_d = m_data_q;
         s_ctrl_d = s_ctrl_q;
         s_data_d = s_data_q;

         case (state_q)
            OCC_EMPTY: begin
               if (in_fire) begin
                  state_d  = OCC_ONE;
                  m_ctrl_d = bus.in_ctrl;
                  m_data_d = bus.in_data;
               end
            end
            OCC_ONE: begin
               if (in_fire && out_fire) begin
                  m_ctrl_d = bus.in_ctrl;
                  m_data_d = bus.in_data;
               end else if (in_fire) begin
                  state_d  = OCC_TWO;
                  s_ctrl_d = bus.in_ctrl;
                  s_data_d = bus.in_data;
               end else if (out_fire) begin
                  state_d = OCC_EMPTY;
               end
            end
            OCC_TWO: begin
               if (out_fire) begin
                  state_d  = OCC_ONE;
                  m_ctrl_d = s_ctrl_q;
                  m_data_d = s_data_q;
               end
            end
            default: state_d = OCC_EMPTY;
         endcase

         // Flush drops everything, including a same-cycle accept, but keeps the
         // last payload visible on out_data.
         if (bus.flush) begin
            state_d  = OCC_EMPTY;
            m_ctrl_d = '0;
            s_ctrl_d = '0;
            m_data_d = m_data_q;
            s_data_d = s_data_q;
         end

         in_ready_d = (state_d != OCC_TWO);
      end

      always_ff @(posedge clk) begin
         if (rst) begin
            state_q    <= OCC_EMPTY;
            in_ready_q <= 1'b0;
            m_ctrl_q   <= '0;
            m_data_q   <= '0;
            s_ctrl_q   <= '0;
            s_data_q   <= '0;
         end else begin
            state_q    <= state_d;
            in_ready_q <= in_ready_d;
            m_ctrl_q   <= m_ctrl_d;
            m_data_q   <= m_data_d;
            s_ctrl_q   <= s_ctrl_d;
            s_data_q   <= s_data_d;
         end
      end

      assign bus.in_ready  = in_ready_q;
      assign bus.out_valid = (state_q != OCC_EMPTY);
      assign bus.out_ctrl  = (state_q != OCC_EMPTY) ? m_ctrl_q : '0;
      assign bus.out_data  = m_data_q;
      assign bus.occ       = occ_count(state_q);
   end else begin : g_single
      logic              m_valid_q, m_valid_d;
      logic              rdy_en_q,  rdy_en_d;
      logic [CTRL_W-1:0] m_ctrl_q,  m_ctrl_d;
      logic [DATA_W-1:0] m_data_q,  m_data_d;

      always_comb begin
         m_valid_d = m_valid_q;
         m_ctrl_d  = m_ctrl_q;
         m_data_d  = m_data_q;
         rdy_en_d  = 1'b1;

         if (in_fire) begin
            m_valid_d = 1'b1;
            m_ctrl_d  = bus.in_ctrl;
            m_data_d  = bus.in_data;
         end else if (out_fire) begin
            m_valid_d = 1'b0;
         end

         if (bus.flush) begin
            m_valid_d = 1'b0;
            m_ctrl_d  = '0;
            m_data_d  = m_data_q;
         end
      end

      always_ff @(posedge clk) begin
         if (rst) begin
            m_valid_q <= 1'b0;
            rdy_en_q  <= 1'b0;
            m_ctrl_q  <= '0;
            m_data_q  <= '0;
         end else begin
            m_valid_q <= m_valid_d;
            rdy_en_q  <= rdy_en_d;
            m_ctrl_q  <= m_ctrl_d;
            m_data_q  <= m_data_d;
         end
      end

      // rdy_en_q holds ready low for the cycle following reset.
      assign bus.in_ready  = rdy_en_q & (bus.out_ready | ~m_valid_q);
      assign bus.out_valid = m_valid_q;
      assign bus.out_ctrl  = m_valid_q ? m_ctrl_q : '0;
      assign bus.out_data  = m_data_q;
      assign bus.occ       = {1'b0, m_valid_q};
   end

   a_bubble_ctrl : assert property (@(posedge clk) disable iff (rst)
      !bus.out_valid |-> (bus.out_ctrl == '0));

   a_occ_range : assert property (@(posedge clk) disable iff (rst)
      bus.occ != 2'd3);

endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb/tb_pipe_stage_reg.sv - scoreboard bench driving SKID=1 and SKID=0 instances in parallel
module tb_pipe_stage_reg;

   typedef struct packed {
      logic [6:0]  c;
      logic [96:0] d;
   } ent_t;

   logic        clk = 1'b0;
   logic        rst;
   logic        flush;
   logic        in_valid;
   logic [6:0]  in_ctrl;
   logic [96:0] in_data;
   logic        out_ready;

   int checks = 0;
   int errors = 0;
   ent_t q1[$];
   ent_t q0[$];

   always #5 clk = ~clk;

   pipe_stage_reg_if #(.CTRL_W(7), .DATA_W(97)) if1 ();
   pipe_stage_reg_if #(.CTRL_W(7), .DATA_W(97)) if0 ();

   assign if1.flush     = flush;
   assign if1.in_valid  = in_valid;
   assign if1.in_ctrl   = in_ctrl;
   assign if1.in_data   = in_data;
   assign if1.out_ready = out_ready;
   assign if0.flush     = flush;
   assign if0.in_valid  = in_valid;
   assign if0.in_ctrl   = in_ctrl;
   assign if0.in_data   = in_data;
   assign if0.out_ready = out_ready;

   pipe_stage_reg #(.CTRL_W(7), .DATA_W(97), .SKID(1'b1)) u_dut_skid (
      .clk (clk),
      .rst (rst),
      .bus (if1)
   );

   pipe_stage_reg #(.CTRL_W(7), .DATA_W(97), .SKID(1'b0)) u_dut_single (
      .clk (clk),
      .rst (rst),
      .bus (if0)
   );

   task automatic drive(input logic v, input logic [6:0] c, input logic [96:0] d,
                        input logic ordy, input logic fl);
      in_valid  = v;
      in_ctrl   = c;
      in_data   = d;
      out_ready = ordy;
      flush     = fl;
      @(negedge clk);
   endtask

   // Scoreboard update for the coming edge, then advance to just after it.
   task automatic adv();
      ent_t e;
      if (if1.out_valid && out_ready) begin
         checks++;
         if (q1.size() == 0) begin
            errors++;
            $display("FAIL sb_skid1: unexpected output ctrl=%h data=%h, required none", if1.out_ctrl, if1.out_data);
         end else begin
            e = q1.pop_front();
            if (if1.out_ctrl !== e.c || if1.out_data !== e.d) begin
               errors++;
               $display("FAIL sb_skid1: got ctrl=%h data=%h, required ctrl=%h data=%h", if1.out_ctrl, if1.out_data, e.c, e.d);
            end
         end
      end
      if (if0.out_valid && out_ready) begin
         checks++;
         if (q0.size() == 0) begin
            errors++;
            $display("FAIL sb_skid0: unexpected output ctrl=%h data=%h, required none", if0.out_ctrl, if0.out_data);
         end else begin
            e = q0.pop_front();
            if (if0.out_ctrl !== e.c || if0.out_data !== e.d) begin
               errors++;
               $display("FAIL sb_skid0: got ctrl=%h data=%h, required ctrl=%h data=%h", if0.out_ctrl, if0.out_data, e.c, e.d);
            end
         end
      end
      if (!if1.out_valid) begin
         checks++;
         if (if1.out_ctrl !== 7'h00) begin
            errors++;
            $display("FAIL bubble_skid1: out_ctrl=%h, required 00", if1.out_ctrl);
         end
      end
      if (!if0.out_valid) begin
         checks++;
         if (if0.out_ctrl !== 7'h00) begin
            errors++;
            $display("FAIL bubble_skid0: out_ctrl=%h, required 00", if0.out_ctrl);
         end
      end
      if (flush) begin
         q1.delete();
         q0.delete();
      end else begin
         if (in_valid && if1.in_ready) q1.push_back(ent_t'({in_ctrl, in_data}));
         if (in_valid && if0.in_ready) q0.push_back(ent_t'({in_ctrl, in_data}));
      end
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1; flush = 1'b0; in_valid = 1'b1; in_ctrl = 7'h7F; in_data = 97'h55; out_ready = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      in_valid = 1'b0;
      @(negedge clk);
      checks++;
      if ({if1.out_valid, if1.out_ctrl, if1.out_data, if1.occ, if1.in_ready} !== '0) begin
         errors++;
         $display("FAIL reset_skid1: valid=%b ctrl=%h data=%h occ=%0d rdy=%b, required all 0",
                  if1.out_valid, if1.out_ctrl, if1.out_data, if1.occ, if1.in_ready);
      end
      checks++;
      if ({if0.out_valid, if0.out_ctrl, if0.out_data, if0.occ, if0.in_ready} !== '0) begin
         errors++;
         $display("FAIL reset_skid0: valid=%b ctrl=%h data=%h occ=%0d rdy=%b, required all 0",
                  if0.out_valid, if0.out_ctrl, if0.out_data, if0.occ, if0.in_ready);
      end
      @(posedge clk);
      #1;
      @(negedge clk);
      checks++;
      if ({if1.in_ready, if0.in_ready} !== 2'b11) begin
         errors++;
         $display("FAIL reset_ready: in_ready skid1=%b skid0=%b, required 1 1", if1.in_ready, if0.in_ready);
      end
      adv();
   endtask

   task automatic test_streaming();
      for (int i = 1; i <= 8; i++) begin
         drive(1'b1, 7'(i), 97'(i), 1'b1, 1'b0);
         checks++;
         if ({if1.in_ready, if0.in_ready} !== 2'b11) begin
            errors++;
            $display("FAIL stream_ready[%0d]: skid1=%b skid0=%b, required 1 1", i, if1.in_ready, if0.in_ready);
         end
         if (i > 1) begin
            checks++;
            if (if1.out_valid !== 1'b1 || if1.out_data !== 97'(i - 1) || if0.out_valid !== 1'b1 || if0.out_data !== 97'(i - 1)) begin
               errors++;
               $display("FAIL stream_latency[%0d]: skid1 v=%b d=%h skid0 v=%b d=%h, required v=1 d=%h",
                        i, if1.out_valid, if1.out_data, if0.out_valid, if0.out_data, 97'(i - 1));
            end
         end
         adv();
      end
      drive(1'b0, 7'h0, 97'h0, 1'b1, 1'b0);
      checks++;
      if (if1.out_data !== 97'd8 || if0.out_data !== 97'd8 || if1.out_valid !== 1'b1 || if0.out_valid !== 1'b1) begin
         errors++;
         $display("FAIL stream_last: skid1 d=%h skid0 d=%h, required 8 valid", if1.out_data, if0.out_data);
      end
      adv();
      drive(1'b0, 7'h0, 97'h0, 1'b1, 1'b0);
      checks++;
      if (if1.out_valid !== 1'b0 || if0.out_valid !== 1'b0) begin
         errors++;
         $display("FAIL stream_drained: valid skid1=%b skid0=%b, required 0 0", if1.out_valid, if0.out_valid);
      end
      adv();
   endtask

   task automatic test_bubble();
      drive(1'b1, 7'h7F, 97'hABC, 1'b1, 1'b0);
      adv();
      drive(1'b0, 7'h0, 97'h0, 1'b1, 1'b0);
      checks++;
      if (if1.out_ctrl !== 7'h7F || if0.out_ctrl !== 7'h7F) begin
         errors++;
         $display("FAIL bubble_live: ctrl skid1=%h skid0=%h, required 7f", if1.out_ctrl, if0.out_ctrl);
      end
      adv();
      drive(1'b0, 7'h0, 97'h0, 1'b1, 1'b0);
      checks++;
      if (if1.out_valid !== 1'b0 || if1.out_ctrl !== 7'h0 || if1.out_data !== 97'hABC ||
          if0.out_valid !== 1'b0 || if0.out_ctrl !== 7'h0 || if0.out_data !== 97'hABC) begin
         errors++;
         $display("FAIL bubble_mask: skid1 v=%b c=%h d=%h skid0 v=%b c=%h d=%h, required v=0 c=0 d=abc",
                  if1.out_valid, if1.out_ctrl, if1.out_data, if0.out_valid, if0.out_ctrl, if0.out_data);
      end
      adv();
   endtask

   task automatic test_backpressure();
      int n;
      drive(1'b1, 7'h1, 97'hA1, 1'b0, 1'b0);
      adv();
      drive(1'b1, 7'h2, 97'hB2, 1'b0, 1'b0);
      checks++;
      if (if0.in_ready !== 1'b0 || if1.in_ready !== 1'b1) begin
         errors++;
         $display("FAIL stall_ready: skid0=%b skid1=%b, required 0 1", if0.in_ready, if1.in_ready);
      end
      adv();
      for (int k = 0; k < 2; k++) begin
         drive(1'b1, 7'h3, 97'hC3, 1'b0, 1'b0);
         checks++;
         if (if1.occ !== 2'd2 || if1.in_ready !== 1'b0 || if1.out_data !== 97'hA1 || if1.out_valid !== 1'b1) begin
            errors++;
            $display("FAIL skid_full[%0d]: occ=%0d rdy=%b v=%b d=%h, required occ=2 rdy=0 v=1 d=a1",
                     k, if1.occ, if1.in_ready, if1.out_valid, if1.out_data);
         end
         adv();
      end
      drive(1'b1, 7'h3, 97'hC3, 1'b1, 1'b0);
      checks++;
      if (if0.in_ready !== 1'b1 || if1.in_ready !== 1'b0) begin
         errors++;
         $display("FAIL release_ready: skid0=%b skid1=%b, required 1 0", if0.in_ready, if1.in_ready);
      end
      adv();
      drive(1'b1, 7'h3, 97'hC3, 1'b1, 1'b0);
      checks++;
      if (if0.out_valid !== 1'b1 || if0.out_data !== 97'hC3 || if1.in_ready !== 1'b1) begin
         errors++;
         $display("FAIL replace: skid0 v=%b d=%h skid1 rdy=%b, required v=1 d=c3 rdy=1", if0.out_valid, if0.out_data, if1.in_ready);
      end
      adv();
      n = 0;
      do begin
         drive(1'b0, 7'h0, 97'h0, 1'b1, 1'b0);
         adv();
         n++;
      end while ((q1.size() != 0 || q0.size() != 0) && n < 10);
      drive(1'b0, 7'h0, 97'h0, 1'b1, 1'b0);
      checks++;
      if (q1.size() != 0 || q0.size() != 0 || if1.occ !== 2'd0 || if0.occ !== 2'd0) begin
         errors++;
         $display("FAIL drain: pending skid1=%0d skid0=%0d occ1=%0d occ0=%0d, required all 0",
                  q1.size(), q0.size(), if1.occ, if0.occ);
      end
      adv();
   endtask

   task automatic test_flush();
      drive(1'b1, 7'h1, 97'hA1, 1'b0, 1'b0);
      adv();
      drive(1'b1, 7'h2, 97'hB2, 1'b0, 1'b0);
      adv();
      drive(1'b1, 7'h44, 97'hD4, 1'b0, 1'b1);
      checks++;
      if (if1.occ !== 2'd2) begin
         errors++;
         $display("FAIL flush_pre: occ=%0d, required 2", if1.occ);
      end
      adv();
      drive(1'b0, 7'h0, 97'h0, 1'b1, 1'b0);
      checks++;
      if (if1.out_valid !== 1'b0 || if1.occ !== 2'd0 || if1.out_ctrl !== 7'h0 || if1.in_ready !== 1'b1 || if1.out_data !== 97'hA1) begin
         errors++;
         $display("FAIL flush_skid1: v=%b occ=%0d c=%h rdy=%b d=%h, required v=0 occ=0 c=0 rdy=1 d=a1",
                  if1.out_valid, if1.occ, if1.out_ctrl, if1.in_ready, if1.out_data);
      end
      checks++;
      if (if0.out_valid !== 1'b0 || if0.occ !== 2'd0 || if0.out_ctrl !== 7'h0 || if0.in_ready !== 1'b1 || if0.out_data !== 97'hA1) begin
         errors++;
         $display("FAIL flush_skid0: v=%b occ=%0d c=%h rdy=%b d=%h, required v=0 occ=0 c=0 rdy=1 d=a1",
                  if0.out_valid, if0.occ, if0.out_ctrl, if0.in_ready, if0.out_data);
      end
      adv();
      for (int k = 0; k < 3; k++) begin
         drive(1'b0, 7'h0, 97'h0, 1'b1, 1'b0);
         checks++;
         if (if1.out_valid !== 1'b0 || if0.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL flush_gone[%0d]: valid skid1=%b skid0=%b, required 0 0", k, if1.out_valid, if0.out_valid);
         end
         adv();
      end
      drive(1'b1, 7'h5, 97'hE5, 1'b1, 1'b0);
      adv();
      drive(1'b1, 7'h6, 97'hF6, 1'b1, 1'b1);
      adv();
      drive(1'b0, 7'h0, 97'h0, 1'b1, 1'b0);
      checks++;
      if (if1.out_valid !== 1'b0 || if0.out_valid !== 1'b0 || if1.out_data !== 97'hE5 || if0.out_data !== 97'hE5) begin
         errors++;
         $display("FAIL flush_accept: skid1 v=%b d=%h skid0 v=%b d=%h, required v=0 d=e5",
                  if1.out_valid, if1.out_data, if0.out_valid, if0.out_data);
      end
      adv();
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      test_reset();
      test_streaming();
      test_bubble();
      test_backpressure();
      test_flush();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
